hamming_tx_scheduler: RTL and testbench

- Shares one Hamming(7,4) encoder between NUM_REQ byte-wide requesters using round-robin arbitration.
- Each granted byte is latched and emitted as two 7-bit codewords, low nibble first, on a valid/ready output stream.
- Each codeword is tagged with the source index and a last flag.
- Sits between the byte producers and the serial link / error-injection channel, upstream of the Hamming decoder.

---
 rtl/hamming_pkg.sv | 20 ++
 rtl/hamming_tx_scheduler_if.sv | 28 ++
 rtl/hamming_tx_scheduler_enc.sv | 20 ++
 rtl/hamming_tx_scheduler.sv | 113 +++++++++++
 tb/tb_hamming_tx_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hamming_pkg.sv
// Shared constants, codeword bit layout and FSM state type for the Hamming(7,4)
// transmit scheduler.
package hamming_pkg;

    localparam int NIBBLE_W = 4;
    localparam int CW_W     = 7;
    localparam int BYTE_W   = 8;

    // Parity bit positions inside the 7-bit codeword; data fills 2, 4, 5, 6
    localparam int P0_POS = 0;
    localparam int P1_POS = 1;
    localparam int P2_POS = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_e;

endpackage

// File: rtl/hamming_tx_scheduler_if.sv
// Requester byte bus plus codeword output stream of the Hamming transmit scheduler.
// master = the scheduler, slave = producers and downstream link seen as one environment.
interface hamming_tx_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = $clog2(NUM_REQ)
) ();

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;

    logic                 cw_valid;
    logic [6:0]           cw_data;
    logic [SRC_W-1:0]     cw_src;
    logic                 cw_last;
    logic                 cw_ready;

    modport master (
        input  req_valid, req_data, cw_ready,
        output req_ready, cw_valid, cw_data, cw_src, cw_last
    );

    modport slave (
        output req_valid, req_data, cw_ready,
        input  req_ready, cw_valid, cw_data, cw_src, cw_last
    );

endinterface

// File: rtl/hamming_tx_scheduler_enc.sv
// Combinational Hamming(7,4) encoder: one nibble in, one 7-bit codeword out.
module hamming_tx_scheduler_enc
    import hamming_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble_i,
    output logic [CW_W-1:0]     cw_o
);

    always_comb begin
        cw_o         = '0;
        cw_o[P0_POS] = nibble_i[0] ^ nibble_i[1] ^ nibble_i[3];
        cw_o[P1_POS] = nibble_i[0] ^ nibble_i[2] ^ nibble_i[3];
        cw_o[P2_POS] = nibble_i[1] ^ nibble_i[2] ^ nibble_i[3];
        cw_o[2]      = nibble_i[0];
        cw_o[4]      = nibble_i[1];
        cw_o[5]      = nibble_i[2];
        cw_o[6]      = nibble_i[3];
    end

endmodule

// File: rtl/hamming_tx_scheduler.sv
// Round-robin byte scheduler feeding one shared Hamming(7,4) encoder, two codewords per byte.
//   state   | meaning
//   IDLE    | scanning requesters, combinational grant, byte latched on handshake
//   SEND_LO | presenting codeword of byte_q[3:0], waiting for cw_ready
//   SEND_HI | presenting codeword of byte_q[7:4] with cw_last, waiting for cw_ready
module hamming_tx_scheduler
    import hamming_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    hamming_tx_scheduler_if.master bus,
    output logic                   busy
);

    state_e               state_q;
    logic [BYTE_W-1:0]    byte_q;
    logic [SRC_W-1:0]     src_q;
    logic [SRC_W-1:0]     rr_ptr_q;
    logic                 cw_valid_q;
    logic                 cw_last_q;
    logic                 busy_q;

    logic                 found_d;
    logic [SRC_W-1:0]     winner_d;
    logic [NIBBLE_W-1:0]  nibble_d;
    logic [CW_W-1:0]      cw_d;

    // Scan starts one past the last winner so every requester gets a turn
    always_comb begin
        int               idx;
        logic [SRC_W-1:0] idx_s;
        found_d  = 1'b0;
        winner_d = '0;
        idx      = 0;
        idx_s    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx   = (int'(rr_ptr_q) + k) % NUM_REQ;
            idx_s = SRC_W'(idx);
            if (!found_d && bus.req_valid[idx_s]) begin
                found_d  = 1'b1;
                winner_d = idx_s;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (!rst && state_q == IDLE && found_d) begin
            bus.req_ready[winner_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_q     <= '0;
            src_q      <= '0;
            rr_ptr_q   <= SRC_W'(NUM_REQ - 1);
            cw_valid_q <= 1'b0;
            cw_last_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        byte_q     <= bus.req_data[BYTE_W*winner_d +: BYTE_W];
                        src_q      <= winner_d;
                        rr_ptr_q   <= winner_d;
                        cw_valid_q <= 1'b1;
                        cw_last_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    if (bus.cw_ready) begin
                        cw_last_q <= 1'b1;
                        state_q   <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (bus.cw_ready) begin
                        cw_valid_q <= 1'b0;
                        cw_last_q  <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // cw_last_q doubles as the nibble select, keeping req_* off the cw_* path
    assign nibble_d = cw_last_q ? byte_q[7:4] : byte_q[3:0];

    hamming_tx_scheduler_enc u_enc (
        .nibble_i (nibble_d),
        .cw_o     (cw_d)
    );

    assign bus.cw_valid = cw_valid_q;
    assign bus.cw_data  = cw_d;
    assign bus.cw_src   = src_q;
    assign bus.cw_last  = cw_last_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_hamming_tx_scheduler.sv
// Scoreboard bench for hamming_tx_scheduler: per-requester byte FIFOs, a positional
// Hamming reference and a round-robin model predict every grant and codeword.
module tb_hamming_tx_scheduler;

    localparam int NR = 4;

    typedef struct packed {
        logic [6:0] data;
        logic [1:0] src;
        logic       last;
    } exp_t;

    logic clk;
    logic rst;
    logic busy;

    hamming_tx_scheduler_if #(.NUM_REQ(NR)) bus ();

    hamming_tx_scheduler #(.NUM_REQ(NR)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.master),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int        tests = 0;
    int        fails = 0;
    int        cyc = 0;
    int        grant_cnt = 0;
    int        model_ptr = NR - 1;
    logic      rand_ready = 1'b0;
    logic [NR-1:0] gnt_seen = '0;

    logic [7:0] fifo [NR][$];
    exp_t       sb[$];
    exp_t       cw_log[$];
    int         grant_log[$];
    int         grant_cyc[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Codeword bit k holds 1-based position k+1; data at 3,5,6,7, parity at powers of two
    function automatic logic [6:0] ref_enc(input logic [3:0] d);
        logic [7:0] code;
        logic       p;
        int         dpos [4];
        dpos = '{3, 5, 6, 7};
        code = '0;
        for (int i = 0; i < 4; i++) code[dpos[i]] = d[i];
        for (int j = 0; j < 3; j++) begin
            p = 1'b0;
            for (int pos = 1; pos < 8; pos++)
                if ((pos & (1 << j)) != 0 && pos != (1 << j)) p = p ^ code[pos];
            code[1 << j] = p;
        end
        return code[7:1];
    endfunction

    function automatic int rr_pick(input logic [NR-1:0] v, input int ptr);
        for (int k = 1; k <= NR; k++) begin
            int idx;
            idx = (ptr + k) % NR;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int pending();
        int n;
        n = 0;
        for (int i = 0; i < NR; i++) n += fifo[i].size();
        return n;
    endfunction

    // Monitor / scoreboard: sampled on the falling edge, between driver updates
    always @(negedge clk) begin
        int         w;
        logic [NR-1:0] exp_mask;
        logic       was_empty;
        logic [7:0] b;
        exp_t       e;
        cyc++;
        if (rst) begin
            chk("req_ready_in_reset", 32'(bus.req_ready), 32'(0));
            sb.delete();
            model_ptr = NR - 1;
            gnt_seen  = '0;
        end else begin
            was_empty = (sb.size() == 0);
            w = -1;
            exp_mask = '0;
            if (was_empty) begin
                w = rr_pick(bus.req_valid, model_ptr);
                if (w >= 0) exp_mask[w] = 1'b1;
            end
            chk("req_ready", 32'(bus.req_ready), 32'(exp_mask));
            chk("busy", 32'(busy), 32'(!was_empty));
            chk("cw_valid", 32'(bus.cw_valid), 32'(!was_empty));
            if (!was_empty) begin
                chk("cw_data", 32'(bus.cw_data), 32'(sb[0].data));
                chk("cw_src", 32'(bus.cw_src), 32'(sb[0].src));
                chk("cw_last", 32'(bus.cw_last), 32'(sb[0].last));
                if (bus.cw_ready) begin
                    cw_log.push_back(sb[0]);
                    void'(sb.pop_front());
                end
            end
            gnt_seen = exp_mask;
            if (w >= 0) begin
                b = bus.req_data[8*w +: 8];
                e.src = 2'(w);
                e.data = ref_enc(b[3:0]); e.last = 1'b0; sb.push_back(e);
                e.data = ref_enc(b[7:4]); e.last = 1'b1; sb.push_back(e);
                model_ptr = w;
                grant_log.push_back(w);
                grant_cyc.push_back(cyc);
                grant_cnt++;
            end
        end
    end

    // Requester driver: present FIFO heads, retire a byte once its grant was taken
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NR; i++)
            if (gnt_seen[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
        for (int i = 0; i < NR; i++) begin
            if (fifo[i].size() > 0) begin
                bus.req_valid[i]       = 1'b1;
                bus.req_data[8*i +: 8] = fifo[i][0];
            end else begin
                bus.req_valid[i]       = 1'b0;
                bus.req_data[8*i +: 8] = 8'h00;
            end
        end
        if (rand_ready) bus.cw_ready = ($urandom_range(3) != 0);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant(input string nm);
        int start;
        int n;
        start = grant_cnt;
        n = 0;
        while (grant_cnt == start && n < 50) begin
            tick();
            n++;
        end
        tests++;
        if (grant_cnt == start) begin
            fails++;
            $display("FAIL %s: no grant within 50 cycles, required one", nm);
        end
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((sb.size() > 0 || pending() > 0) && n < 3000) begin
            tick();
            n++;
        end
        tests++;
        if (sb.size() > 0 || pending() > 0) begin
            fails++;
            $display("FAIL %s: %0d codewords and %0d bytes still pending, required 0", nm, sb.size(), pending());
        end
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         gl;
        int         cl;
        logic [6:0] corner_exp [8];
        int         rr_exp [5];
        corner_exp = '{7'h00, 7'h00, 7'h7F, 7'h7F, 7'h07, 7'h19, 7'h2A, 7'h4B};
        rr_exp     = '{0, 1, 2, 3, 0};

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.cw_ready  = 1'b0;
        do_reset();

        chk("reset_cw_valid", 32'(bus.cw_valid), 32'(0));
        chk("reset_cw_data", 32'(bus.cw_data), 32'(0));
        chk("reset_cw_src", 32'(bus.cw_src), 32'(0));
        chk("reset_cw_last", 32'(bus.cw_last), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_req_ready", 32'(bus.req_ready), 32'(0));

        // Single byte 0xA5 from requester 0
        bus.cw_ready = 1'b1;
        fifo[0].push_back(8'hA5);
        wait_grant("a5_grant");
        chk("a5_lo_valid", 32'(bus.cw_valid), 32'(1));
        chk("a5_lo_data", 32'(bus.cw_data), 32'h2D);
        chk("a5_lo_last", 32'(bus.cw_last), 32'(0));
        chk("a5_lo_src", 32'(bus.cw_src), 32'(0));
        tick();
        chk("a5_hi_data", 32'(bus.cw_data), 32'h52);
        chk("a5_hi_last", 32'(bus.cw_last), 32'(1));
        drain("a5_drain");

        // Encoder corners from requester 1
        cl = cw_log.size();
        fifo[1].push_back(8'h00);
        fifo[1].push_back(8'hFF);
        fifo[1].push_back(8'h21);
        fifo[1].push_back(8'h84);
        drain("corner_drain");
        chk("corner_count", 32'(cw_log.size() - cl), 32'(8));
        if (cw_log.size() >= cl + 8) begin
            for (int k = 0; k < 8; k++) begin
                chk("corner_data", 32'(cw_log[cl+k].data), 32'(corner_exp[k]));
                chk("corner_src", 32'(cw_log[cl+k].src), 32'(1));
            end
        end

        // Backpressure held during the low codeword of 0x1B
        bus.cw_ready = 1'b0;
        fifo[0].push_back(8'h1B);
        wait_grant("bp_grant");
        fifo[2].push_back(8'hC3);
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_data", 32'(bus.cw_data), 32'(ref_enc(4'hB)));
            chk("bp_hold_last", 32'(bus.cw_last), 32'(0));
            chk("bp_req_ready", 32'(bus.req_ready), 32'(0));
            tick();
        end
        bus.cw_ready = 1'b1;
        tick();
        chk("bp_hi_data", 32'(bus.cw_data), 32'h07);
        chk("bp_hi_last", 32'(bus.cw_last), 32'(1));
        drain("bp_drain");

        // Round-robin with all four requesters valid from reset
        do_reset();
        gl = grant_log.size();
        fifo[0].push_back(8'h3E);
        fifo[0].push_back(8'h9D);
        fifo[1].push_back(8'h4F);
        fifo[2].push_back(8'h60);
        fifo[3].push_back(8'hB7);
        drain("rr_drain");
        chk("rr_grant_count", 32'(grant_log.size() - gl), 32'(5));
        if (grant_log.size() >= gl + 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("rr_order", 32'(grant_log[gl+k]), 32'(rr_exp[k]));
                if (k > 0) chk("rr_spacing", 32'(grant_cyc[gl+k] - grant_cyc[gl+k-1]), 32'(3));
            end
        end

        // Reset while the high codeword is on the output
        do_reset();
        fifo[1].push_back(8'h3C);
        wait_grant("mid_grant");
        fifo[0].push_back(8'h11);
        fifo[2].push_back(8'h22);
        tick();
        chk("mid_in_send_hi", 32'(bus.cw_last), 32'(1));
        rst = 1'b1;
        tick();
        chk("mid_rst_cw_valid", 32'(bus.cw_valid), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        rst = 1'b0;
        gl = grant_log.size();
        wait_grant("post_rst_grant");
        if (grant_log.size() > gl) chk("post_rst_first", 32'(grant_log[gl]), 32'(0));
        drain("mid_drain");

        // Idle gap, then rotation continues from the last winner
        fifo[1].push_back(8'h5A);
        drain("gap_pre_drain");
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("gap_cw_valid", 32'(bus.cw_valid), 32'(0));
            chk("gap_req_ready", 32'(bus.req_ready), 32'(0));
            chk("gap_busy", 32'(busy), 32'(0));
        end
        gl = grant_log.size();
        fifo[0].push_back(8'h66);
        fifo[2].push_back(8'h77);
        wait_grant("gap_grant");
        if (grant_log.size() > gl) chk("gap_rotation", 32'(grant_log[gl]), 32'(2));
        drain("gap_drain");

        // Random traffic with random backpressure
        rand_ready = 1'b1;
        for (int k = 0; k < 400; k++) begin
            tick();
            if ($urandom_range(2) == 0) fifo[$urandom_range(NR - 1)].push_back(8'($urandom));
        end
        rand_ready   = 1'b0;
        bus.cw_ready = 1'b1;
        drain("rand_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
